map_memory_ctrl: RTL
====================

// Module: map_memory_ctrl
// PURPOSE
//  Multi-bank tile-map memory shared by the Avalon-MM bus (CPU side) and the VGA tile renderer.
//  Holds NUM_MAPS level maps. VGA reads the active bank; the CPU edits any bank.
//  Active-bank switches are deferred to a frame boundary. A hardware fill engine clears a bank.
// PARAMETERS
//  DATA_W      32  word width (multiple of 8; byte enables are DATA_W/8 wide)
//  VGA_ADDR_W  12  word address width of one map bank (2**VGA_ADDR_W words per bank)
//  NUM_MAPS     4  number of map banks (>=2); MAP_W = $clog2(NUM_MAPS)
//  RD_LATENCY   2  read latency in clocks for both ports (>=1)
// PORTS
//  Clk             in   1              system clock
//  RESET           in   1              asynchronous, active-high reset
//  AVL_CS          in   1              Avalon-MM chip select
//  AVL_READ        in   1              Avalon-MM read, qualified by AVL_CS
//  AVL_WRITE       in   1              Avalon-MM write, qualified by AVL_CS
//  AVL_BYTE_EN     in   DATA_W/8       write byte enables
//  AVL_ADDR        in   VGA_ADDR_W+1   MSB=0: word in edit bank; MSB=1: CSR, low 2 bits index
//  AVL_WRITEDATA   in   DATA_W         write data
//  AVL_READDATA    out  DATA_W         read data, valid with AVL_READDATAVALID
//  AVL_READDATAVALID out 1             one pulse per accepted read
//  AVL_WAITREQUEST out  1              stall; the request is held by the master
//  VGA_ADDR        in   VGA_ADDR_W     renderer word address, sampled every cycle
//  VGA_FRAME_START in   1              one-cycle pulse at start of vertical blank
//  VGA_Q           out  DATA_W         word at VGA_ADDR from the active bank, RD_LATENCY later
//  ACTIVE_MAP      out  MAP_W          bank currently shown to VGA
// BEHAVIOUR
//  CSR map (AVL_ADDR MSB=1):
//   0 ACT_REQ   R/W  requested active bank. Read returns the pending value.
//   1 EDIT_SEL  R/W  bank targeted by memory-window accesses.
//   2 FILL_CTL  W: bit0=start. R: bit0=busy, bit1=done (sticky). Any write with bit1=1 clears done.
//   3 FILL_VAL  R/W  word written by the fill engine.
//  CSR values >= NUM_MAPS are stored modulo NUM_MAPS.
//  Reset values: AVL_READDATA=0, AVL_READDATAVALID=0, AVL_WAITREQUEST=0, VGA_Q=0,
//   ACTIVE_MAP=0, ACT_REQ=0, EDIT_SEL=0, FILL_VAL=0, busy=0, done=0, FSM=IDLE.
//   The fill address counter and the read pipelines are cleared. Bank contents are not cleared.
//  VGA port: fixed pipeline. VGA_Q(t+RD_LATENCY) = bank[ACTIVE_MAP][VGA_ADDR(t)] with ACTIVE_MAP taken at t.
//   The VGA port is never stalled.
//  Bank switch: ACTIVE_MAP <= ACT_REQ only in the cycle VGA_FRAME_START=1.
//   A write to ACT_REQ in that same cycle takes effect at the next frame start.
//  Avalon memory window:
//   Write: byte-enabled, completes in one cycle when not stalled.
//   Read: AVL_READDATAVALID pulses RD_LATENCY cycles after acceptance. Accepted reads stay in order.
//   CSR reads use the same latency.
//   AVL_READ and AVL_WRITE both high: the write wins and the read is ignored.
//  Fill FSM, states IDLE -> FILL -> IDLE:
//   IDLE -> FILL on a write to FILL_CTL with bit0=1. busy=1; the address counter loads 0.
//   The bank to fill is EDIT_SEL, latched at start.
//   FILL: writes FILL_VAL (latched at start) to addr++ with full byte enables, one word per cycle.
//   At addr=2**VGA_ADDR_W-1 the FSM writes that word, then returns to IDLE with busy=0 and done=1.
//   A start while busy is ignored.
//  While busy, AVL_WAITREQUEST=1 for memory-window accesses (MSB=0). CSR accesses are never stalled.
//   Exception: writes to EDIT_SEL or FILL_VAL are stalled while busy.
//  Read-during-write, same bank and address, same cycle: the read returns the old data on both ports.
//   The new data is visible to reads issued from the next cycle.
//  Filling the active bank is legal; VGA sees a mix of old and new words until done.
//  RESET asserted mid-fill aborts it and the bank holds partial contents.
//   Pending reads are dropped and no AVL_READDATAVALID is produced for them.
// TESTING
//  1 Reset, then write 0xDEADBEEF to window 0x005 with EDIT_SEL=0, BYTE_EN=4'b0101, over prior 0
//    -> read returns 0x00AD00EF, AVL_READDATAVALID exactly RD_LATENCY cycles after acceptance.
//  2 Write ACT_REQ=2 mid-frame -> ACTIVE_MAP stays 0 until the VGA_FRAME_START pulse, then becomes 2.
//    VGA_Q switches to bank-2 data RD_LATENCY cycles later.
//  3 Set EDIT_SEL=1 and FILL_VAL=0x7, then start the fill
//    -> busy for 2**VGA_ADDR_W cycles, then done=1; every bank-1 word is 0x7 and bank 0 is unchanged.
//  4 During that fill, issue a window read -> AVL_WAITREQUEST=1 until busy falls.
//    Meanwhile a FILL_CTL read -> no stall, returns busy=1.
//  5 Same-cycle write 0x11 and VGA read at the same address of the active bank -> VGA_Q shows old data.
//    The next VGA read of that address shows 0x11.
//  6 Assert RESET halfway through a fill with a read in flight
//    -> all outputs reset, no stray AVL_READDATAVALID, filled words retained.

Source files
------------

// File: rtl/map_memory_ctrl.sv
// Multi-bank tile-map memory: Avalon-MM edit port, fixed-latency VGA read
// port, frame-synchronous bank switching and a hardware bank fill engine.
module map_memory_ctrl #(
  parameter  int DATA_W     = 32,
  parameter  int VGA_ADDR_W = 12,
  parameter  int NUM_MAPS   = 4,
  parameter  int RD_LATENCY = 2,
  localparam int MAP_W      = $clog2(NUM_MAPS),
  localparam int BE_W       = DATA_W / 8,
  localparam int DEPTH      = 2 ** VGA_ADDR_W
) (
  input  logic                  Clk,
  input  logic                  RESET,
  input  logic                  AVL_CS,
  input  logic                  AVL_READ,
  input  logic                  AVL_WRITE,
  input  logic [BE_W-1:0]       AVL_BYTE_EN,
  input  logic [VGA_ADDR_W:0]   AVL_ADDR,
  input  logic [DATA_W-1:0]     AVL_WRITEDATA,
  output logic [DATA_W-1:0]     AVL_READDATA,
  output logic                  AVL_READDATAVALID,
  output logic                  AVL_WAITREQUEST,
  input  logic [VGA_ADDR_W-1:0] VGA_ADDR,
  input  logic                  VGA_FRAME_START,
  output logic [DATA_W-1:0]     VGA_Q,
  output logic [MAP_W-1:0]      ACTIVE_MAP
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [NUM_MAPS*DEPTH];

  logic [MAP_W-1:0]      act_req;
  logic [MAP_W-1:0]      edit_sel;
  logic [MAP_W-1:0]      fill_bank;
  logic [DATA_W-1:0]     fill_val;
  logic [DATA_W-1:0]     fill_word;
  logic [VGA_ADDR_W-1:0] fill_addr;
  logic                  done;
  logic                  busy;

  logic                  is_csr;
  logic [1:0]            csr_idx;
  logic [VGA_ADDR_W-1:0] win_addr;
  logic                  stall;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  fill_we;
  logic                  fill_last;
  logic                  fill_start;
  logic [DATA_W-1:0]     csr_rdata;

  logic [DATA_W-1:0]     avl_pipe [RD_LATENCY];
  logic [DATA_W-1:0]     vga_pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] vld_pipe;

  assign is_csr   = AVL_ADDR[VGA_ADDR_W];
  assign csr_idx  = AVL_ADDR[1:0];
  assign win_addr = AVL_ADDR[VGA_ADDR_W-1:0];
  assign busy     = (state == FILL);

  // EDIT_SEL and FILL_VAL writes would disturb a fill in progress
  always_comb begin
    stall = 1'b0;
    if (busy && AVL_CS && (AVL_READ || AVL_WRITE)) begin
      stall = !is_csr ||
              (AVL_WRITE && (csr_idx == 2'd1 || csr_idx == 2'd3));
    end
  end

  assign AVL_WAITREQUEST = stall;
  assign wr_ok = AVL_CS && AVL_WRITE && !stall;
  assign rd_ok = AVL_CS && AVL_READ && !AVL_WRITE && !stall;

  always_comb begin
    csr_rdata = '0;
    case (csr_idx)
      2'd0: csr_rdata = DATA_W'(act_req);
      2'd1: csr_rdata = DATA_W'(edit_sel);
      2'd2: csr_rdata = DATA_W'({done, busy});
      2'd3: csr_rdata = fill_val;
      default: csr_rdata = '0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    fill_we   = 1'b0;
    fill_last = (fill_addr == '1);
    unique case (state)
      IDLE: begin
        if (wr_ok && is_csr && csr_idx == 2'd2 && AVL_WRITEDATA[0])
          state_nx = FILL;
      end
      FILL: begin
        fill_we = 1'b1;
        if (fill_last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fill_start = (state == IDLE) && (state_nx == FILL);

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      act_req    <= '0;
      edit_sel   <= '0;
      fill_val   <= '0;
      fill_bank  <= '0;
      fill_word  <= '0;
      fill_addr  <= '0;
      done       <= 1'b0;
      ACTIVE_MAP <= '0;
    end else begin
      if (wr_ok && is_csr) begin
        case (csr_idx)
          2'd0: act_req  <= MAP_W'(AVL_WRITEDATA % DATA_W'(NUM_MAPS));
          2'd1: edit_sel <= MAP_W'(AVL_WRITEDATA % DATA_W'(NUM_MAPS));
          2'd3: fill_val <= AVL_WRITEDATA;
          default: ;
        endcase
        if (csr_idx == 2'd2 && AVL_WRITEDATA[1])
          done <= 1'b0;
      end
      if (fill_we && fill_last)
        done <= 1'b1;
      if (fill_start) begin
        fill_addr <= '0;
        fill_bank <= edit_sel;
        fill_word <= fill_val;
      end else if (fill_we) begin
        fill_addr <= fill_addr + 1'b1;
      end
      if (VGA_FRAME_START)
        ACTIVE_MAP <= act_req;
    end
  end

  // Storage is deliberately not reset so an aborted fill leaves partial data
  always_ff @(posedge Clk) begin
    if (fill_we) begin
      mem[{fill_bank, fill_addr}] <= fill_word;
    end else if (wr_ok && !is_csr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (AVL_BYTE_EN[b])
          mem[{edit_sel, win_addr}][b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        avl_pipe[i] <= '0;
        vga_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_ok;
      if (rd_ok)
        avl_pipe[0] <= is_csr ? csr_rdata : mem[{edit_sel, win_addr}];
      vga_pipe[0] <= mem[{ACTIVE_MAP, VGA_ADDR}];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        avl_pipe[i] <= avl_pipe[i-1];
        vga_pipe[i] <= vga_pipe[i-1];
      end
    end
  end

  assign AVL_READDATA      = avl_pipe[RD_LATENCY-1];
  assign AVL_READDATAVALID = vld_pipe[RD_LATENCY-1];
  assign VGA_Q             = vga_pipe[RD_LATENCY-1];

endmodule
